i2c_reg_bank: RTL

I2C_REG_BANK -- requirements
Module: i2c_reg_bank

---
 rtl/i2c_reg_bank_if.sv | 37 +++
 rtl/i2c_reg_bank.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bank_if.sv
// i2c_reg_bank_pkg / i2c_reg_bank_if
//
// Shared byte type and the byte-level bus between an I2C slave core and the
// register bank.
//
// Interface signals:
//   addr     8  start address presented by the slave core
//   ptrLoad  1  pulse: load the register pointer from addr
//   dataIn   8  write byte
//   writeEn  1  pulse: dataIn is to be written at the current address
//   readEn   1  pulse: the current read byte has been consumed
//   dataOut  8  registered read byte from the bank
//
// Modports: master = slave core side, slave = register bank side.

package i2c_reg_bank_pkg;
    typedef logic [7:0] i2c_data_t;
endpackage

interface i2c_reg_bank_if;
    logic [7:0] addr;
    logic       ptrLoad;
    logic [7:0] dataIn;
    logic       writeEn;
    logic       readEn;
    logic [7:0] dataOut;

    modport master (
        output addr, ptrLoad, dataIn, writeEn, readEn,
        input  dataOut
    );

    modport slave (
        input  addr, ptrLoad, dataIn, writeEn, readEn,
        output dataOut
    );
endinterface

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank
//
// Byte-addressed register bank behind an I2C slave core. An auto-incrementing
// pointer walks a flat map of read/write control registers, synchronised
// read-only input registers, sticky write-1-to-clear status registers and
// their interrupt-enable registers.
//
// Address map (NO/NI/NS = output/input/status register counts):
//   [0, NO)              output (control) registers, per-bit write mask
//   [NO, NO+NI)          input registers (2-flop synchronised), read-only
//   [NO+NI, NO+NI+NS)    status registers, event set / write-1 clear
//   [NO+NI+NS, N)        interrupt-enable registers, N = NO+NI+2*NS
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   bus      byte bus from the slave core (slave modport)
//   outputs  control register contents
//   inputs   asynchronous status inputs
//   events   per-bit status set pulses
//   irq      registered interrupt: OR of (status & irqEn)

module i2c_reg_bank
    import i2c_reg_bank_pkg::*;
#(
    parameter int unsigned                    C_NUM_OUTPUT_REGS = 4,
    parameter int unsigned                    C_NUM_INPUT_REGS  = 4,
    parameter int unsigned                    C_NUM_STATUS_REGS = 2,
    parameter logic [C_NUM_OUTPUT_REGS*8-1:0] C_RESET_VAL       = '0,
    parameter logic [C_NUM_OUTPUT_REGS*8-1:0] C_WR_MASK         = '1
) (
    input  logic                                clk,
    input  logic                                rst,
    i2c_reg_bank_if.slave                       bus,
    output i2c_data_t [C_NUM_OUTPUT_REGS-1:0]   outputs,
    input  i2c_data_t [C_NUM_INPUT_REGS-1:0]    inputs,
    input  i2c_data_t [C_NUM_STATUS_REGS-1:0]   events,
    output logic                                irq
);

    localparam int unsigned NO      = C_NUM_OUTPUT_REGS;
    localparam int unsigned NI      = C_NUM_INPUT_REGS;
    localparam int unsigned NS      = C_NUM_STATUS_REGS;
    localparam int unsigned IN_BASE = NO;
    localparam int unsigned ST_BASE = NO + NI;
    localparam int unsigned IE_BASE = NO + NI + NS;
    localparam int unsigned N       = NO + NI + 2 * NS;

    // Pointer and effective address
    logic [7:0] ptr;
    logic [7:0] ea;
    logic [8:0] ea_inc;
    logic [7:0] ptr_next;
    logic       adv;

    // Register storage
    i2c_data_t [NO-1:0] out_q;
    i2c_data_t [NI-1:0] sync1_q;
    i2c_data_t [NI-1:0] sync2_q;
    i2c_data_t [NS-1:0] status_q;
    i2c_data_t [NS-1:0] irq_en_q;

    // Write decode
    logic      [NO-1:0] wr_out;
    logic      [NS-1:0] wr_ie;
    i2c_data_t [NS-1:0] status_clr;

    i2c_data_t rd_data;
    i2c_data_t data_out_q;
    logic      irq_next;
    logic      irq_q;

    // Pointer: load overrides, any access advances by one, wrap past the map.
    always_comb begin
        ea     = bus.ptrLoad ? bus.addr : ptr;
        adv    = bus.writeEn | bus.readEn;
        ea_inc = {1'b0, ea} + 9'd1;
        if (!adv) begin
            ptr_next = ea;
        end else if (ea_inc >= 9'(N)) begin
            ptr_next = '0;
        end else begin
            ptr_next = ea_inc[7:0];
        end
    end

    always_comb begin
        wr_out     = '0;
        wr_ie      = '0;
        status_clr = '0;
        for (int unsigned i = 0; i < NO; i++) begin
            wr_out[i] = bus.writeEn && (ea == 8'(i));
        end
        for (int unsigned j = 0; j < NS; j++) begin
            wr_ie[j] = bus.writeEn && (ea == 8'(IE_BASE + j));
            if (bus.writeEn && (ea == 8'(ST_BASE + j))) begin
                status_clr[j] = bus.dataIn;
            end
        end
    end

    // Read data is fetched at the pointer value being loaded this edge, so
    // dataOut always shows the byte at ptr one cycle after it moves.
    // Unmapped addresses read as zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NO; i++) begin
            if (ptr_next == 8'(i)) rd_data = out_q[i];
        end
        for (int unsigned i = 0; i < NI; i++) begin
            if (ptr_next == 8'(IN_BASE + i)) rd_data = sync2_q[i];
        end
        for (int unsigned j = 0; j < NS; j++) begin
            if (ptr_next == 8'(ST_BASE + j)) rd_data = status_q[j];
            if (ptr_next == 8'(IE_BASE + j)) rd_data = irq_en_q[j];
        end
    end

    always_comb begin
        irq_next = 1'b0;
        for (int unsigned j = 0; j < NS; j++) begin
            irq_next = irq_next | (|(status_q[j] & irq_en_q[j]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            data_out_q <= '0;
            out_q      <= C_RESET_VAL;
            sync1_q    <= '0;
            sync2_q    <= '0;
            status_q   <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            ptr        <= ptr_next;
            data_out_q <= rd_data;
            sync1_q    <= inputs;
            sync2_q    <= sync1_q;
            irq_q      <= irq_next;
            for (int unsigned i = 0; i < NO; i++) begin
                if (wr_out[i]) begin
                    out_q[i] <= (out_q[i] & ~C_WR_MASK[i*8 +: 8])
                              | (bus.dataIn & C_WR_MASK[i*8 +: 8]);
                end
            end
            for (int unsigned j = 0; j < NS; j++) begin
                // Event set is applied after the clear so a same-cycle event wins.
                status_q[j] <= (status_q[j] & ~status_clr[j]) | events[j];
                if (wr_ie[j]) begin
                    irq_en_q[j] <= bus.dataIn;
                end
            end
        end
    end

    assign bus.dataOut = data_out_q;
    assign outputs     = out_q;
    assign irq         = irq_q;

endmodule
